// File: rtl/sar_search.sv
// Successive-approximation search engine driving the probe side of a magnitude comparator.
// Optional SAR_STEP_COUNT_EN adds a per-search SAMPLE-cycle counter on output steps.
module sar_search #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             eq,
    input  logic             lt,
    input  logic             gt,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result
`ifdef SAR_STEP_COUNT_EN
    ,
    output logic [$clog2(WIDTH+2)-1:0] steps
`endif
);

    localparam int unsigned BW = WIDTH + 1;
    localparam logic [WIDTH-1:0] PMAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] PINIT = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [BW-1:0]    HMAX  = {1'b0, {WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [BW-1:0]    lo_q, lo_d, hi_q, hi_d;
    logic [BW-1:0]    lo_n, hi_n;
    logic [WIDTH-1:0] probe_q, probe_d, result_q, result_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             found_q, found_d, err_q, err_d;

    // Midpoint of the current bounds, truncated to probe width
    function automatic logic [WIDTH-1:0] mid(input logic [BW-1:0] lo, input logic [BW-1:0] hi);
        logic [BW-1:0] m;
        m = lo + ((hi - lo) >> 1);
        return m[WIDTH-1:0];
    endfunction

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        lo_n     = lo_q;
        hi_n     = hi_q;
        probe_d  = probe_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        found_d  = found_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lo_d     = '0;
                    hi_d     = HMAX;
                    probe_d  = PINIT;
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                    result_d = '0;
                    busy_d   = 1'b1;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: state_d = S_SAMPLE;
            S_SAMPLE: begin
                state_d = S_DONE;
                case ({eq, lt, gt})
                    3'b100: begin
                        found_d  = 1'b1;
                        result_d = probe_q;
                    end
                    3'b010: begin
                        if (probe_q == PMAX) begin
                            err_d = 1'b1;
                        end else begin
                            lo_n    = BW'(probe_q) + BW'(1);
                            lo_d    = lo_n;
                            probe_d = mid(lo_n, hi_q);
                            state_d = S_SETTLE;
                        end
                    end
                    3'b001: begin
                        if (probe_q == '0) begin
                            err_d = 1'b1;
                        end else begin
                            hi_n    = BW'(probe_q) - BW'(1);
                            hi_d    = hi_n;
                            probe_d = mid(lo_q, hi_n);
                            state_d = S_SETTLE;
                        end
                    end
                    default: err_d = 1'b1;
                endcase
                // Search ends: drop busy and pulse done on entry to DONE
                if (state_d == S_DONE) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            lo_q     <= '0;
            hi_q     <= HMAX;
            probe_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            probe_q  <= probe_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    assign probe  = probe_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign found  = found_q;
    assign err    = err_q;
    assign result = result_q;

`ifdef SAR_STEP_COUNT_EN
    localparam int unsigned SW = $clog2(WIDTH + 2);
    logic [SW-1:0] steps_q, steps_d;

    // Counts SAMPLE cycles of the current search
    always_comb begin
        steps_d = steps_q;
        if (state_q == S_IDLE && start) begin
            steps_d = '0;
        end else if (state_q == S_SAMPLE) begin
            steps_d = steps_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            steps_q <= '0;
        end else begin
            steps_q <= steps_d;
        end
    end

    assign steps = steps_q;
`endif

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: behavioural comparator against a hidden target,
// with forced-flag overrides for the error paths.
module tb_sar_search;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       eq, lt, gt;
    logic [7:0] probe, result;
    logic       busy, done, found, err;
`ifdef SAR_STEP_COUNT_EN
    logic [3:0] steps;
`endif

    logic [7:0] target;
    logic       fe;
    logic [2:0] fflags;
    int         checks   = 0;
    int         failures = 0;
    int         exp_p[$];

    always #5 clk = ~clk;

    // Comparator model with an override for illegal/forced flag patterns
    assign eq = fe ? fflags[2] : (probe == target);
    assign lt = fe ? fflags[1] : (probe < target);
    assign gt = fe ? fflags[0] : (probe > target);

    sar_search #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .eq    (eq),
        .lt    (lt),
        .gt    (gt),
        .probe (probe),
        .busy  (busy),
        .done  (done),
        .found (found),
        .err   (err),
        .result(result)
`ifdef SAR_STEP_COUNT_EN
        ,
        .steps (steps)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full search; exp_p holds the expected probe sequence
    task automatic run(input logic [7:0] tgt, input bit hold, input bit e_found, input bit e_err,
                       input logic [7:0] e_res, input int e_steps, input string tag);
        target = tgt;
        start  = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_clr_found"}, 32'(found), 32'd0);
        chk({tag, "_clr_err"}, 32'(err), 32'd0);
        chk({tag, "_clr_result"}, 32'(result), 32'd0);
        for (int k = 0; k < exp_p.size(); k++) begin
            chk($sformatf("%s_probe%0d", tag, k), 32'(probe), 32'(exp_p[k]));
            tick();
            tick();
        end
        start = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_found"}, 32'(found), 32'(e_found));
        chk({tag, "_err"}, 32'(err), 32'(e_err));
        chk({tag, "_result"}, 32'(result), 32'(e_res));
`ifdef SAR_STEP_COUNT_EN
        chk({tag, "_steps"}, 32'(steps), 32'(e_steps));
`endif
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        if (e_steps < 0) $display("unexpected negative step count");
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        target = 8'd0;
        fe     = 1'b0;
        fflags = 3'b000;
        #12;
        chk("rst_probe", 32'(probe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_found", 32'(found), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
`ifdef SAR_STEP_COUNT_EN
        chk("rst_steps", 32'(steps), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        exp_p = '{127, 63, 95, 111, 103, 99, 101, 100};
        run(8'd100, 1'b0, 1'b1, 1'b0, 8'd100, 8, "t100");

        exp_p = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
        run(8'd255, 1'b0, 1'b1, 1'b0, 8'd255, 9, "t255");

        exp_p = '{127, 63, 31, 15, 7, 3, 1, 0};
        run(8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 8, "t0");

        // eq and lt both high on the third SAMPLE
        target = 8'd100;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (4) tick();
        chk("eqlt_probe3", 32'(probe), 32'd95);
        fe     = 1'b1;
        fflags = 3'b110;
        tick();
        tick();
        chk("eqlt_done", 32'(done), 32'd1);
        chk("eqlt_err", 32'(err), 32'd1);
        chk("eqlt_found", 32'(found), 32'd0);
        chk("eqlt_result", 32'(result), 32'd0);
`ifdef SAR_STEP_COUNT_EN
        chk("eqlt_steps", 32'(steps), 32'd3);
`endif
        fe = 1'b0;
        tick();
        chk("eqlt_done_pulse", 32'(done), 32'd0);
        chk("eqlt_err_held", 32'(err), 32'd1);

        // start held high throughout the search is ignored; also clears err
        exp_p = '{127, 63, 95, 111, 103, 99, 101, 100};
        run(8'd100, 1'b1, 1'b1, 1'b0, 8'd100, 8, "hold");
        repeat (3) tick();
        chk("hold_result_idle", 32'(result), 32'd100);
        chk("hold_busy_idle", 32'(busy), 32'd0);

        fe     = 1'b1;
        fflags = 3'b001;
        exp_p  = '{127, 63, 31, 15, 7, 3, 1, 0};
        run(8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 8, "allgt");
        chk("allgt_probe_hold", 32'(probe), 32'd0);

        fflags = 3'b010;
        exp_p  = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
        run(8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 9, "alllt");
        chk("alllt_probe_hold", 32'(probe), 32'd255);
        fe = 1'b0;

        // Asynchronous reset mid-search
        target = 8'd50;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (3) tick();
        chk("mid_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("mid_probe", 32'(probe), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_found", 32'(found), 32'd0);
        chk("mid_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        exp_p = '{127, 63, 31, 47, 55, 51, 49, 50};
        run(8'd50, 1'b0, 1'b1, 1'b0, 8'd50, 8, "t50");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sar_search.md
Name: sar_search

Overview:
- Successive-approximation search engine that drives the probe side of a magnitude comparator.
- Issues a probe value, consumes the comparator's eq/lt/gt flags, and binary-searches the full unsigned range for the hidden comparand.
- Reports the matching value, or an error when the flags are inconsistent.
- Sits upstream of a comparator instance; the comparand is the comparator's other operand, invisible to this block.

Parameters:
- WIDTH, 8, bit width of the probe and result.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a search; sampled only in IDLE.
- eq  input  1  comparator flag: probe == target.
- lt  input  1  comparator flag: probe < target.
- gt  input  1  comparator flag: probe > target.
- probe  output  WIDTH  value presented to the comparator.
- busy  output  1  high while a search is in progress.
- done  output  1  one-cycle pulse when a search ends.
- found  output  1  last search ended on eq; held until the next start.
- err  output  1  last search ended on an illegal flag combination or range exhaustion; held until the next start.
- result  output  WIDTH  matched value when found=1, else 0; held until the next start.

Behaviour:
- Clocking: one clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE; lo=0; hi=2^WIDTH-1; probe=0; busy=0; done=0; found=0; err=0; result=0.
- Reset mid-search aborts immediately to IDLE with the reset values above.
- Internal bounds: lo and hi are WIDTH+1-bit unsigned registers. Probe is registered and computed as lo + ((hi-lo)>>1), truncated to WIDTH bits.
- IDLE:
  - start=1 → load lo=0, hi=2^WIDTH-1, probe=2^(WIDTH-1)-1.
  - Clear found, err and result; set busy=1; go to SETTLE.
  - start=0 → stay in IDLE.
- SETTLE:
  - One cycle with probe stable so the external combinational comparator settles. Go to SAMPLE.
- SAMPLE: flags are sampled on this cycle's edge.
  - eq only → found=1, result=probe, go to DONE.
  - lt only:
    - If probe==2^WIDTH-1 → err=1, go to DONE.
    - Else lo=probe+1, probe recomputed from the new bounds, go to SETTLE.
  - gt only:
    - If probe==0 → err=1, go to DONE.
    - Else hi=probe-1, probe recomputed, go to SETTLE.
  - Any other combination (none high, or more than one high) → err=1, go to DONE.
- DONE:
  - done=1 for exactly this cycle; busy=0 from this cycle onward. Go to IDLE.
- Latency:
  - 2 cycles per probe; at most WIDTH+1 probes.
  - done asserts the cycle after the final SAMPLE.
  - With a well-behaved comparator, err never asserts, because the range cannot empty before eq.
- start while busy or in DONE is ignored; no queueing.
- probe holds its last value in IDLE and DONE.
- found and err are never both 1.

Optional Feature:
- Macro: SAR_STEP_COUNT_EN.
- When defined:
  - Adds output steps, width $clog2(WIDTH+2).
  - Counts SAMPLE cycles in the current search; cleared on an accepted start; held after done until the next start; resets to 0.
- When undefined: no steps port and no counter logic; all other behaviour identical.

Test Plan:
- Bench models comparator vs target; WIDTH=8; target=100; pulse start → probe sequence 127,63,95,111,103,99,101,100; done pulses once; found=1, result=100, err=0, steps=8.
- target=255 → probes 127,191,223,239,247,251,253,254,255; found=1, result=255, steps=9 (max); done 18 cycles after the start edge.
- target=0 → probes 127,63,31,15,7,3,1,0; found=1, result=0; at no point does probe go below 0.
- Bench forces eq=lt=1 during the 3rd SAMPLE → err=1, found=0, result=0, done pulses once; the next start clears err.
- Bench forces gt=1 at every probe → hi walks down to probe=0, then err=1 with no wrap-around; forced lt=1 ends at probe=255 with err=1.
- start asserted during busy → ignored, result unchanged. rst_n low mid-search → busy, done, found, err and probe return to 0 asynchronously; a new start after release completes normally.
